div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multi-cycle divide sequencer serving the EX stage for DIV/DIVU.
- EX raises a request with two 32-bit operands. The block latches them, runs a radix-2 restoring division (one quotient bit per clock), and holds the pipeline via a stall request until the result is ready.
- Result {remainder, quotient} returns to EX for the HI/LO write path.
- Annul input lets pipeline control kill an in-flight divide on flush.

Parameters:
- WIDTH, 32, operand width; quotient and remainder each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start_i  input  1  EX requests a divide; held high until ready_o is seen.
- annul_i  input  1  cancel current or pending divide (flush/exception).
- signed_div_i  input  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  input  WIDTH  dividend; sampled only at acceptance.
- opdata2_i  input  WIDTH  divisor; sampled only at acceptance.
- result_o  output  2*WIDTH  {remainder, quotient}; valid while ready_o=1.
- ready_o  output  1  result valid.
- stallreq_o  output  1  combinational request to pipeline control to freeze IF..EX.

Behaviour:
- Reset: state=FREE, cnt=0, ready_o=0, result_o=0, internal dividend/divisor registers=0. Applies in any state, including mid-iteration.
- States: FREE, BYZERO, ON, END.
- FREE:
  - If start_i=1 and annul_i=0, accept the request (cycle 0) and latch the operands.
  - For signed divides, latch absolute values and record the sign flags.
  - Next state: BYZERO if divisor==0, else ON with cnt=0.
  - Otherwise stay in FREE, with ready_o=0 and result_o=0.
- BYZERO: next state END with result_o=0. ready_o rises in cycle 2.
- ON:
  - Each cycle: shift the partial remainder left, bringing in the next dividend bit (MSB first).
  - If partial remainder >= divisor: subtract and shift in quotient bit 1; else shift in 0.
  - Increment cnt each cycle.
  - After the WIDTH-th iteration (cycles 1..32), go to END.
  - If annul_i=1 in any ON cycle: go to FREE next cycle and discard all work; ready_o never rises.
- END:
  - Sign fix-up is applied on the edge entering END:
    - Quotient is negated if signed and the operand signs differ.
    - Remainder is negated if signed and the dividend is negative.
  - ready_o=1 from cycle 33 (cycle 2 for divide-by-zero).
  - result_o is held stable while start_i=1.
  - When start_i=0: go to FREE next cycle, and ready_o and result_o clear to 0.
  - annul_i in END also returns to FREE.
- stallreq_o = start_i & ~annul_i & ~(state==END). The stall is therefore asserted from cycle 0 through the last ON cycle and drops in the cycle ready_o rises.
- Arithmetic rules:
  - Comparison and subtraction are (WIDTH+1)-bit unsigned on the magnitudes.
  - Signed -2^31 / -1 wraps: quotient=0x80000000, remainder=0.
  - An unsigned divisor of 0 never enters ON.
- Operand changes on opdata*_i after acceptance are ignored.
- start_i deasserted mid-ON without annul is a protocol error. The block continues to END, then returns to FREE.
- Back-to-back: a new request is accepted only from FREE, i.e. at least one cycle after END.

Decomposition:
- Shared defines in the common header:
  - State encodings: DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - DivStart/DivStop, DivResultReady/DivResultNotReady.
  - Existing ZeroWord and RegBus.
- One natural sub-module, div_step: the combinational single-iteration compare/subtract/shift. It is instantiated once and registered by div_seq.

Test Plan:
- Reset idle → ready_o=0, result_o=0, stallreq_o=0.
- Unsigned division: DIVU 100/7 with start held → stallreq_o=1 on cycles 0..32; ready_o=1 at cycle 33; result_o=0x00000002_0000000E; stallreq_o=0. Drop start → FREE, result_o=0 next cycle.
- Signed division, three cases:
  - DIV -7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - DIV 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
  - DIV 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divide by zero: DIVU 5/0 → ready_o=1 at cycle 2, result_o=0.
- Annul at iteration 10 → FREE next cycle, ready_o stays 0, stallreq_o drops that cycle. A new DIVU 0xFFFFFFFF/1 then gives quotient 0xFFFFFFFF, remainder 0 at +33.
- Reset asserted at iteration 20 → all outputs 0 next cycle. The following request completes normally with correct latency.

Source files
------------

// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared definitions for the multi-cycle divide sequencer.
//   - DivState encodings for the sequencer FSM
//   - start/stop and result-ready encodings used on the EX handshake
//   - RegBus / ZeroWord as used across the EX stage
package div_seq_pkg;

  localparam int RegBus = 32;
  localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

  localparam int DIV_WIDTH = RegBus;
  localparam int DIV_CNT_W = 6;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: EX <-> divide sequencer handshake.
//   master (EX side): drives start_i, annul_i, signed_div_i, opdata1_i, opdata2_i
//   slave  (div_seq): drives result_o {remainder, quotient}, ready_o, stallreq_o
interface div_seq_if
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic               start_i;
  logic               annul_i;
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stallreq_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stallreq_o
  );

endinterface

// File: rtl/div_seq_step.sv
// div_step: one radix-2 restoring division iteration (combinational).
//   rem_i     : partial remainder before this step (always < divisor_i)
//   bit_i     : next dividend bit, MSB first
//   divisor_i : divisor magnitude
//   rem_o     : partial remainder after this step
//   q_o       : quotient bit produced by this step
module div_step
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  assign shifted_s = {rem_i, bit_i};
  assign diff_s    = shifted_s - {1'b0, divisor_i};

  // With rem_i < divisor_i the shifted value is below 2*divisor, so the
  // (WIDTH+1)-bit difference has its MSB clear exactly when shifted >= divisor.
  assign q_o   = ~diff_s[WIDTH];
  assign rem_o = q_o ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle DIV/DIVU sequencer for the EX stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : div_seq_if.slave -- start/annul/signed/operands in,
//              {remainder, quotient}, ready and pipeline stall request out
// One quotient bit per clock on operand magnitudes; signs are restored on
// the edge entering END. Divide-by-zero skips iteration and returns zero.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  localparam logic [WIDTH-1:0]   OneW     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ZeroW    = WIDTH'(ZeroWord);
  localparam logic [2*WIDTH-1:0] ZeroRes  = {(2*WIDTH){1'b0}};
  localparam logic [CNT_W-1:0]   CntZero  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CntOne   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0]   CntLast  = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
    if (neg) begin
      return (~v) + OneW;
    end else begin
      return v;
    end
  endfunction

  div_state_e         state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  // dividend_r shifts out dividend bits at the top and collects quotient bits at the bottom
  logic [WIDTH-1:0]   dividend_r, dividend_s;
  logic [WIDTH-1:0]   divisor_r, divisor_s;
  logic [WIDTH-1:0]   rem_r, rem_s;
  logic               quot_neg_r, quot_neg_s;
  logic               rem_neg_r, rem_neg_s;
  logic [2*WIDTH-1:0] result_r, result_s;
  logic               ready_r, ready_s;

  logic               op1_neg_s, op2_neg_s;
  logic [WIDTH-1:0]   op1_abs_s, op2_abs_s;
  logic [WIDTH-1:0]   step_rem_s;
  logic               step_q_s;
  logic [WIDTH-1:0]   quot_fin_s;

  assign op1_neg_s  = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign op2_neg_s  = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign op1_abs_s  = cond_neg(op1_neg_s, bus.opdata1_i);
  assign op2_abs_s  = cond_neg(op2_neg_s, bus.opdata2_i);
  assign quot_fin_s = {dividend_r[WIDTH-2:0], step_q_s};

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_r),
    .bit_i     (dividend_r[WIDTH-1]),
    .divisor_i (divisor_r),
    .rem_o     (step_rem_s),
    .q_o       (step_q_s)
  );

  // Next-state and next-datapath values for the sequencer.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    dividend_s = dividend_r;
    divisor_s  = divisor_r;
    rem_s      = rem_r;
    quot_neg_s = quot_neg_r;
    rem_neg_s  = rem_neg_r;
    result_s   = result_r;
    ready_s    = ready_r;
    case (state_r)
      DivFree: begin
        ready_s  = DivResultNotReady;
        result_s = ZeroRes;
        if ((bus.start_i == DivStart) && !bus.annul_i) begin
          dividend_s = op1_abs_s;
          divisor_s  = op2_abs_s;
          rem_s      = ZeroW;
          cnt_s      = CntZero;
          quot_neg_s = op1_neg_s ^ op2_neg_s;
          rem_neg_s  = op1_neg_s;
          if (bus.opdata2_i == ZeroW) begin
            state_s = DivByZero;
          end else begin
            state_s = DivOn;
          end
        end else begin
          state_s = DivFree;
        end
      end
      DivByZero: begin
        if (bus.annul_i) begin
          state_s = DivFree;
        end else begin
          state_s  = DivEnd;
          result_s = ZeroRes;
          ready_s  = DivResultReady;
        end
      end
      DivOn: begin
        if (bus.annul_i) begin
          state_s  = DivFree;
          cnt_s    = CntZero;
          result_s = ZeroRes;
          ready_s  = DivResultNotReady;
        end else begin
          dividend_s = quot_fin_s;
          rem_s      = step_rem_s;
          cnt_s      = cnt_r + CntOne;
          if (cnt_r == CntLast) begin
            state_s  = DivEnd;
            result_s = {cond_neg(rem_neg_r, step_rem_s), cond_neg(quot_neg_r, quot_fin_s)};
            ready_s  = DivResultReady;
          end else begin
            state_s = DivOn;
          end
        end
      end
      DivEnd: begin
        if ((bus.start_i == DivStop) || bus.annul_i) begin
          state_s  = DivFree;
          result_s = ZeroRes;
          ready_s  = DivResultNotReady;
        end else begin
          state_s = DivEnd;
        end
      end
      default: begin
        state_s  = DivFree;
        result_s = ZeroRes;
        ready_s  = DivResultNotReady;
      end
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= DivFree;
      cnt_r      <= CntZero;
      dividend_r <= ZeroW;
      divisor_r  <= ZeroW;
      rem_r      <= ZeroW;
      quot_neg_r <= 1'b0;
      rem_neg_r  <= 1'b0;
      result_r   <= ZeroRes;
      ready_r    <= DivResultNotReady;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      dividend_r <= dividend_s;
      divisor_r  <= divisor_s;
      rem_r      <= rem_s;
      quot_neg_r <= quot_neg_s;
      rem_neg_r  <= rem_neg_s;
      result_r   <= result_s;
      ready_r    <= ready_s;
    end
  end

  assign bus.result_o   = result_r;
  assign bus.ready_o    = ready_r;
  assign bus.stallreq_o = (bus.start_i == DivStart) & ~bus.annul_i & (state_r != DivEnd);

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  div_seq_if bus ();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // behavioural model state: 0 idle, 1 busy, 2 result available
  int          m_phase = 0;
  int          m_wait = 0;
  logic [63:0] m_res = 64'd0;
  bit          m_valid = 1'b0;
  bit          m_after_rst = 1'b0;

  // directed pins: main posts an id, compare process retires it
  int          pin_id = 0;
  int          done_id = 0;
  int          pin_cnt = 0;
  int          pin_lat = 0;
  logic [63:0] pin_res = 64'd0;

  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0000_0000, 32'h8000_0000};
    sa = a; sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sr, sq};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // model advances on the same edge as the DUT, from the inputs held across it
  always @(posedge clk) begin
    if (rst) begin
      m_phase     = 0;
      m_valid     = 1'b1;
      m_after_rst = 1'b1;
    end else begin
      m_after_rst = 1'b0;
      case (m_phase)
        0: if (bus.start_i && !bus.annul_i) begin
             m_res   = ref_div(bus.signed_div_i, bus.opdata1_i, bus.opdata2_i);
             m_wait  = (bus.opdata2_i == 32'd0) ? 1 : 32;
             m_phase = 1;
           end
        1: if (bus.annul_i) m_phase = 0;
           else begin
             m_wait--;
             if (m_wait == 0) m_phase = 2;
           end
        default: if (!bus.start_i || bus.annul_i) m_phase = 0;
      endcase
    end
  end

  // per-cycle compare against the model, plus directed literal pins
  always @(negedge clk) begin
    if (m_valid) begin
      chk("ready_o", {63'd0, bus.ready_o}, {63'd0, m_phase == 2});
      chk("result_o", bus.result_o, (m_phase == 2) ? m_res : 64'd0);
      chk("stallreq_o", {63'd0, bus.stallreq_o},
          {63'd0, bus.start_i & ~bus.annul_i & (m_phase != 2)});
      if (m_after_rst) begin
        chk("rst_ready", {63'd0, bus.ready_o}, 64'd0);
        chk("rst_result", bus.result_o, 64'd0);
      end
      if (pin_id != done_id) begin
        if (bus.ready_o) begin
          chk("latency", 64'(pin_cnt), 64'(pin_lat));
          chk("pin_result", bus.result_o, pin_res);
          done_id = pin_id;
          pin_cnt = 0;
        end else if (pin_cnt >= 100) begin
          chk("ready_timeout", 64'(pin_cnt), 64'(pin_lat));
          done_id = pin_id;
          pin_cnt = 0;
        end else begin
          pin_cnt++;
        end
      end
    end
  end

  task automatic begin_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res, input int lat);
    begin_div(sgn, a, b);
    pin_res = res;
    pin_lat = lat;
    pin_id++;
    for (int k = 0; k < 130 && done_id != pin_id; k++) begin
      @(negedge clk);
      if (k == 2) begin
        bus.opdata1_i = ~a;
        bus.opdata2_i = 32'h0000_0003;
      end
    end
    repeat (2) @(posedge clk);
    #1 bus.start_i = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    run_div(1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33);
    run_div(1'b0, 32'd5, 32'd0, 64'd0, 2);
    run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 64'd0, 2);
    run_div(1'b0, 32'd7, 32'd9, 64'h0000_0007_0000_0000, 33);

    // annul in the 10th iteration
    begin_div(1'b0, 32'd12345, 32'd17);
    repeat (10) @(posedge clk);
    #1 bus.annul_i = 1'b1;
    @(posedge clk);
    #1 bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, 33);

    // reset in the 20th iteration
    begin_div(1'b0, 32'd1000, 32'd3);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    run_div(1'b0, 32'd1000, 32'd3, 64'h0000_0001_0000_014D, 33);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
